jt08_adpcm_ram_arb: RTL and testbench
=====================================

Name: jt08_adpcm_ram_arb

Overview:
- Arbiter for the single external ADPCM RAM port.
- Shares the port between the ADPCM-B driver (port A, real-time playback/record) and a secondary requester (port B, e.g. FDD/host DMA).
- Provides fixed priority to A with a starvation guard for B, a variable-latency memory handshake, and a timeout so a stalled memory never hangs playback.
- Sits between jt08_adpcm_drvB's RAM strobes (after a small req/ack adapter) and the board memory controller.

Parameters:
- STARVE_MAX, 3: consecutive A grants while B is pending, after which B is forced next.
- TIMEOUT, 15: cycles waiting for mem_ack before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- a_req  in  1  port A request, level, held until a_ack.
- a_we  in  1  port A write (1) / read (0).
- a_addr  in  24  port A byte address.
- a_wdata  in  8  port A write data.
- a_ack  out  1  port A completion pulse.
- a_rdata  out  8  port A read data.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: same widths and meanings for port B.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  24  memory address.
- mem_wdata  out  8  memory write data.
- mem_ack  in  1  memory completion, one-cycle pulse.
- mem_rdata  in  8  memory read data, valid with mem_ack.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky timeout flag.
- err_clr  in  1  clears timeout_err.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State is IDLE. starve_cnt=0, tmo_cnt=0.
  - All outputs are 0, including a_rdata, b_rdata, mem_addr and mem_wdata.
  - mem_req drops immediately. An in-flight access is abandoned with no ack to either port.
- States:
  - IDLE → WAIT → DONE → IDLE.
- IDLE:
  - Sample a_req and b_req.
  - Neither asserted: stay in IDLE.
  - Exactly one asserted: grant it.
  - Both asserted: grant A, unless starve_cnt==STARVE_MAX, in which case grant B.
  - On grant: latch owner, we, addr and wdata into mem_* outputs, then go to WAIT.
- starve_cnt:
  - +1 (saturating at STARVE_MAX) when A is granted while b_req=1.
  - Cleared when B is granted, or when b_req=0 in IDLE.
- WAIT:
  - mem_req=1 with all mem_* outputs stable.
  - mem_ack=1: capture mem_rdata into the owner's rdata (reads only; writes leave rdata unchanged), drop mem_req, go to DONE.
  - Otherwise tmo_cnt increments. When TIMEOUT≠0 and tmo_cnt==TIMEOUT-1 without ack: drop mem_req, owner rdata=8'hFF on a read, set timeout_err, go to DONE.
  - tmo_cnt clears on entry to WAIT.
- DONE:
  - One-cycle owner ack (a_ack or b_ack), then go to IDLE.
  - The IDLE cycle that follows is mandatory, so a requester still holding req is re-arbitrated and never bypasses arbitration.
- Latency:
  - Request seen in IDLE at cycle 0 → mem_req at cycle 1.
  - mem_ack at cycle k≥1 → ack at cycle k+1.
  - Minimum 2 cycles from request to ack; minimum 3 cycles between successive grants.
- Data hold: a_rdata and b_rdata hold until the next completing read on the same port.
- Requester protocol: req and its payload must stay stable until ack. Payload changes after grant are ignored; the latched values are used. Dropping req before ack does not cancel the access; the ack still pulses.
- mem_ack outside WAIT is ignored.
- timeout_err:
  - Set by a timeout, cleared by err_clr.
  - Simultaneous timeout and err_clr: set wins.
- busy=1 in WAIT and DONE.

Optional Feature:
- Macro JT08_ARB_STATS_EN.
- Defined: adds outputs a_gnt_cnt[15:0], b_gnt_cnt[15:0] and tmo_cnt_tot[7:0].
  - a_gnt_cnt / b_gnt_cnt: wrapping grant counters.
  - tmo_cnt_tot: saturating timeout count.
  - All three reset to 0 by rst_n; err_clr does not clear them.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Single A read, addr=24'h000123, mem_ack one cycle after mem_req with rdata=8'h5A → a_ack at cycle 2, a_rdata=8'h5A, b_ack never asserted.
- a_req and b_req held continuously, STARVE_MAX=3, immediate mem_ack → grant order A,A,A,B,A,A,A,B…; each grant separated by 3 cycles.
- B write addr=24'h1FFFFF, wdata=8'hC3, mem_ack delayed 10 cycles → mem_we=1, mem_wdata=8'hC3 held stable for all 10 cycles; b_ack 1 cycle after mem_ack; b_rdata unchanged.
- A read with no mem_ack, TIMEOUT=15 → mem_req drops after 15 cycles, a_rdata=8'hFF, a_ack pulses, timeout_err=1; err_clr pulse → timeout_err=0; a mem_ack arriving afterwards is ignored.
- rst_n asserted mid-WAIT → mem_req=0 in the same cycle, no ack, all outputs 0; after release, a fresh A request completes normally.
- With JT08_ARB_STATS_EN: 5 A grants, 2 B grants, 1 timeout → a_gnt_cnt=5, b_gnt_cnt=2, tmo_cnt_tot=1.

Source files
------------

// File: rtl/jt08_adpcm_ram_arb.sv
// jt08_adpcm_ram_arb: arbiter for the single external ADPCM RAM port.
// Shares the memory between port A (ADPCM-B driver, real-time) and port B
// (secondary requester such as FDD/host DMA). A has fixed priority; B is
// forced through after STARVE_MAX consecutive A grants while it waits. A
// stalled memory is aborted after TIMEOUT cycles (0 disables the abort).
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata   port A request (level, held until a_ack)
//   a_ack/a_rdata               port A completion pulse and read data
//   b_*                         same for port B
//   mem_req/mem_we/mem_addr/mem_wdata  memory request, held until mem_ack
//   mem_ack/mem_rdata           memory completion pulse and read data
//   busy                        high whenever not IDLE
//   timeout_err/err_clr         sticky timeout flag and its clear
//
// Optional feature macro JT08_ARB_STATS_EN: adds a_gnt_cnt, b_gnt_cnt
// (wrapping grant counters) and tmo_cnt_tot (saturating timeout count).
module jt08_adpcm_ram_arb #(
  parameter int unsigned STARVE_MAX = 3,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [23:0] a_addr,
  input  logic [7:0]  a_wdata,
  output logic        a_ack,
  output logic [7:0]  a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [23:0] b_addr,
  input  logic [7:0]  b_wdata,
  output logic        b_ack,
  output logic [7:0]  b_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [23:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic        timeout_err,
  input  logic        err_clr
`ifdef JT08_ARB_STATS_EN
  ,
  output logic [15:0] a_gnt_cnt,
  output logic [15:0] b_gnt_cnt,
  output logic [7:0]  tmo_cnt_tot
`endif
);

  localparam int unsigned AW = 24;
  localparam int unsigned DW = 8;
  localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t          state, state_n;
  logic            owner_b, owner_b_n;
  logic [SW-1:0]   starve_cnt, starve_cnt_n;
  logic [TW-1:0]   tmo_cnt, tmo_cnt_n;
  logic            mem_req_n, mem_we_n;
  logic [AW-1:0]   mem_addr_n;
  logic [DW-1:0]   mem_wdata_n;
  logic            a_ack_n, b_ack_n;
  logic [DW-1:0]   a_rdata_n, b_rdata_n;
  logic            busy_n, timeout_err_n;
  logic            pick_b_c;
  logic            tmo_hit_c;
`ifdef JT08_ARB_STATS_EN
  logic [15:0]     a_gnt_cnt_n, b_gnt_cnt_n;
  logic [7:0]      tmo_cnt_tot_n;
`endif

  // Next-state and next-output logic; every register has its next value here.
  always_comb begin
    state_n       = state;
    owner_b_n     = owner_b;
    starve_cnt_n  = starve_cnt;
    tmo_cnt_n     = tmo_cnt;
    mem_req_n     = mem_req;
    mem_we_n      = mem_we;
    mem_addr_n    = mem_addr;
    mem_wdata_n   = mem_wdata;
    a_ack_n       = 1'b0;
    b_ack_n       = 1'b0;
    a_rdata_n     = a_rdata;
    b_rdata_n     = b_rdata;
    timeout_err_n = timeout_err;
    pick_b_c      = 1'b0;
    tmo_hit_c     = 1'b0;
`ifdef JT08_ARB_STATS_EN
    a_gnt_cnt_n   = a_gnt_cnt;
    b_gnt_cnt_n   = b_gnt_cnt;
    tmo_cnt_tot_n = tmo_cnt_tot;
`endif

    case (state)
      IDLE: begin
        if (!b_req) starve_cnt_n = '0;
        if (a_req || b_req) begin
          // B wins only when alone or when A has starved it long enough.
          pick_b_c    = b_req && (!a_req || (starve_cnt == SW'(STARVE_MAX)));
          owner_b_n   = pick_b_c;
          mem_req_n   = 1'b1;
          mem_we_n    = pick_b_c ? b_we    : a_we;
          mem_addr_n  = pick_b_c ? b_addr  : a_addr;
          mem_wdata_n = pick_b_c ? b_wdata : a_wdata;
          tmo_cnt_n   = '0;
          state_n     = WAIT;
          if (pick_b_c) begin
            starve_cnt_n = '0;
`ifdef JT08_ARB_STATS_EN
            b_gnt_cnt_n  = b_gnt_cnt + 16'd1;
`endif
          end else begin
            if (b_req && (starve_cnt != SW'(STARVE_MAX)))
              starve_cnt_n = starve_cnt + SW'(1);
`ifdef JT08_ARB_STATS_EN
            a_gnt_cnt_n  = a_gnt_cnt + 16'd1;
`endif
          end
        end
      end

      WAIT: begin
        if (mem_ack) begin
          mem_req_n = 1'b0;
          if (!mem_we) begin
            if (owner_b) b_rdata_n = mem_rdata;
            else         a_rdata_n = mem_rdata;
          end
          a_ack_n = !owner_b;
          b_ack_n = owner_b;
          state_n = DONE;
        end else if ((TIMEOUT != 0) && (tmo_cnt == TW'(TIMEOUT - 1))) begin
          // Abort: reads return all-ones so playback sees a defined value.
          tmo_hit_c = 1'b1;
          mem_req_n = 1'b0;
          if (!mem_we) begin
            if (owner_b) b_rdata_n = 8'hFF;
            else         a_rdata_n = 8'hFF;
          end
          a_ack_n = !owner_b;
          b_ack_n = owner_b;
          state_n = DONE;
`ifdef JT08_ARB_STATS_EN
          if (tmo_cnt_tot != 8'hFF) tmo_cnt_tot_n = tmo_cnt_tot + 8'd1;
`endif
        end else begin
          tmo_cnt_n = tmo_cnt + TW'(1);
        end
      end

      DONE: begin
        // Always pass through IDLE so a held request is re-arbitrated.
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase

    // A timeout in the same cycle as err_clr leaves the flag set.
    if (err_clr)   timeout_err_n = 1'b0;
    if (tmo_hit_c) timeout_err_n = 1'b1;

    busy_n = (state_n != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner_b     <= 1'b0;
      starve_cnt  <= '0;
      tmo_cnt     <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
      a_rdata     <= '0;
      b_rdata     <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
`ifdef JT08_ARB_STATS_EN
      a_gnt_cnt   <= '0;
      b_gnt_cnt   <= '0;
      tmo_cnt_tot <= '0;
`endif
    end else begin
      state       <= state_n;
      owner_b     <= owner_b_n;
      starve_cnt  <= starve_cnt_n;
      tmo_cnt     <= tmo_cnt_n;
      mem_req     <= mem_req_n;
      mem_we      <= mem_we_n;
      mem_addr    <= mem_addr_n;
      mem_wdata   <= mem_wdata_n;
      a_ack       <= a_ack_n;
      b_ack       <= b_ack_n;
      a_rdata     <= a_rdata_n;
      b_rdata     <= b_rdata_n;
      busy        <= busy_n;
      timeout_err <= timeout_err_n;
`ifdef JT08_ARB_STATS_EN
      a_gnt_cnt   <= a_gnt_cnt_n;
      b_gnt_cnt   <= b_gnt_cnt_n;
      tmo_cnt_tot <= tmo_cnt_tot_n;
`endif
    end
  end

endmodule

// File: tb/tb_jt08_adpcm_ram_arb.sv
// Directed testbench for jt08_adpcm_ram_arb (STARVE_MAX=3, TIMEOUT=15).
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_jt08_adpcm_ram_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [23:0] a_addr, b_addr;
  logic [7:0]  a_wdata, b_wdata;
  logic        a_ack, b_ack;
  logic [7:0]  a_rdata, b_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [23:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        busy, timeout_err, err_clr;
`ifdef JT08_ARB_STATS_EN
  logic [15:0] a_gnt_cnt, b_gnt_cnt;
  logic [7:0]  tmo_cnt_tot;
`endif

  int checks   = 0;
  int failures = 0;

  jt08_adpcm_ram_arb #(.STARVE_MAX(3), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr)
`ifdef JT08_ARB_STATS_EN
    , .a_gnt_cnt(a_gnt_cnt), .b_gnt_cnt(b_gnt_cnt), .tmo_cnt_tot(tmo_cnt_tot)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    mem_ack = 0; mem_rdata = '0; err_clr = 0;
    #1;
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_a_rdata", 32'(a_rdata), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // 1) single A read, ack one cycle after mem_req
    a_req = 1; a_we = 0; a_addr = 24'h000123;
    tick();
    check("t1_mem_req", 32'(mem_req), 1);
    check("t1_mem_addr", 32'(mem_addr), 32'h000123);
    check("t1_mem_we", 32'(mem_we), 0);
    check("t1_busy", 32'(busy), 1);
    mem_ack = 1; mem_rdata = 8'h5A;
    tick();
    check("t1_a_ack", 32'(a_ack), 1);
    check("t1_b_ack", 32'(b_ack), 0);
    check("t1_a_rdata", 32'(a_rdata), 32'h5A);
    check("t1_mem_req_drop", 32'(mem_req), 0);
    mem_ack = 0; a_req = 0;
    tick();
    check("t1_a_ack_low", 32'(a_ack), 0);
    check("t1_idle", 32'(busy), 0);
    tick();

    // 2) both held, immediate acks: A,A,A,B,A,A,A,B, one grant per 3 cycles
    a_req = 1; a_we = 0; a_addr = 24'h0AAAAA;
    b_req = 1; b_we = 0; b_addr = 24'h0BBBBB;
    for (int i = 0; i < 8; i++) begin
      logic exp_b;
      exp_b = (i % 4) == 3;
      check("t2_idle_busy", 32'(busy), 0);
      tick();
      check("t2_grant_addr", 32'(mem_addr), exp_b ? 32'h0BBBBB : 32'h0AAAAA);
      mem_ack = 1; mem_rdata = 8'(i);
      tick();
      mem_ack = 0;
      check("t2_a_ack", 32'(a_ack), exp_b ? 0 : 1);
      check("t2_b_ack", 32'(b_ack), exp_b ? 1 : 0);
      tick();
    end
    a_req = 0; b_req = 0;
    check("t2_a_rdata", 32'(a_rdata), 32'h06);
    check("t2_b_rdata", 32'(b_rdata), 32'h07);
    tick();

    // 3) B write, mem_ack on the 10th WAIT cycle; payload change after grant ignored
    b_req = 1; b_we = 1; b_addr = 24'h1FFFFF; b_wdata = 8'hC3;
    tick();
    b_wdata = 8'h00; b_addr = 24'h000000;
    for (int i = 0; i < 10; i++) begin
      check("t3_mem_req", 32'(mem_req), 1);
      check("t3_mem_we", 32'(mem_we), 1);
      check("t3_mem_wdata", 32'(mem_wdata), 32'hC3);
      check("t3_mem_addr", 32'(mem_addr), 32'h1FFFFF);
      check("t3_b_ack_wait", 32'(b_ack), 0);
      if (i == 9) mem_ack = 1;
      tick();
    end
    mem_ack = 0;
    check("t3_b_ack", 32'(b_ack), 1);
    check("t3_b_rdata_kept", 32'(b_rdata), 32'h07);
    check("t3_timeout_err", 32'(timeout_err), 0);
    b_req = 0; b_we = 0;
    tick();
    check("t3_b_ack_low", 32'(b_ack), 0);
    tick();

    // 4) A read with no mem_ack: abort after 15 WAIT cycles; err_clr races the set
    a_req = 1; a_we = 0; a_addr = 24'h000777;
    tick();
    for (int i = 0; i < 15; i++) begin
      check("t4_mem_req", 32'(mem_req), 1);
      check("t4_a_ack_wait", 32'(a_ack), 0);
      if (i == 14) err_clr = 1;
      tick();
    end
    err_clr = 0;
    check("t4_mem_req_drop", 32'(mem_req), 0);
    check("t4_a_ack", 32'(a_ack), 1);
    check("t4_a_rdata_ff", 32'(a_rdata), 32'hFF);
    check("t4_timeout_err", 32'(timeout_err), 1);
    a_req = 0;
    tick();
    check("t4_err_sticky", 32'(timeout_err), 1);
    err_clr = 1;
    tick();
    err_clr = 0;
    check("t4_err_cleared", 32'(timeout_err), 0);
    mem_ack = 1; mem_rdata = 8'h11;
    tick();
    mem_ack = 0;
    check("t4_late_ack_a", 32'(a_ack), 0);
    check("t4_late_ack_b", 32'(b_ack), 0);
    check("t4_late_rdata", 32'(a_rdata), 32'hFF);
    check("t4_late_busy", 32'(busy), 0);
`ifdef JT08_ARB_STATS_EN
    check("st_a_gnt", 32'(a_gnt_cnt), 8);
    check("st_b_gnt", 32'(b_gnt_cnt), 3);
    check("st_tmo", 32'(tmo_cnt_tot), 1);
`endif

    // 5) reset in the middle of WAIT, then a fresh A read
    a_req = 1; a_we = 0; a_addr = 24'h000456;
    tick();
    check("t5_mem_req", 32'(mem_req), 1);
    tick();
    rst_n = 0;
    #1;
    check("t5_rst_mem_req", 32'(mem_req), 0);
    check("t5_rst_mem_addr", 32'(mem_addr), 0);
    check("t5_rst_a_rdata", 32'(a_rdata), 0);
    check("t5_rst_b_rdata", 32'(b_rdata), 0);
    check("t5_rst_busy", 32'(busy), 0);
    a_req = 0;
    mem_ack = 1;
    tick();
    mem_ack = 0;
    check("t5_rst_no_ack", 32'(a_ack), 0);
    rst_n = 1;
    tick();
    a_req = 1; a_addr = 24'h000789;
    tick();
    check("t5_fresh_addr", 32'(mem_addr), 32'h000789);
    mem_ack = 1; mem_rdata = 8'h3C;
    tick();
    mem_ack = 0; a_req = 0;
    check("t5_fresh_ack", 32'(a_ack), 1);
    check("t5_fresh_rdata", 32'(a_rdata), 32'h3C);
`ifdef JT08_ARB_STATS_EN
    check("st_a_gnt_after_rst", 32'(a_gnt_cnt), 1);
    check("st_b_gnt_after_rst", 32'(b_gnt_cnt), 0);
    check("st_tmo_after_rst", 32'(tmo_cnt_tot), 0);
`endif
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
